// File: rtl/mat_mem_sequencer.sv
// mat_mem_sequencer: sequences matrix memory reads/writes around the exe engine for one instruction at a time
module mat_mem_sequencer #(
  parameter int MAT_W = 256,
  parameter int PTR_W = 3,
  parameter int NUM_ENTRIES = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_op,
  input  logic [PTR_W-1:0] instr_src1,
  input  logic [PTR_W-1:0] instr_src2,
  input  logic [PTR_W-1:0] instr_dst,
  input  logic [MAT_W-1:0] store_data,
  output logic [PTR_W-1:0] mem_pointer1,
  output logic [PTR_W-1:0] mem_pointer2,
  output logic             mem_read_data,
  output logic             mem_write_data,
  output logic [PTR_W-1:0] mem_write_pointer,
  output logic [MAT_W-1:0] mem_data_to_write,
  input  logic [MAT_W-1:0] mem_data1,
  input  logic [MAT_W-1:0] mem_data2,
  output logic [MAT_W-1:0] opa,
  output logic [MAT_W-1:0] opb,
  output logic             opnd_valid,
  input  logic             opnd_ready,
  input  logic [MAT_W-1:0] res_data,
  input  logic             res_valid,
  output logic             res_ready,
  output logic             txn_done,
  output logic             err_illegal
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, OPND, WAIT_RES, WRITE, DONE} state_t;
  localparam logic [PTR_W-1:0] LIM = PTR_W'(NUM_ENTRIES);
  state_t state;
  logic [1:0] op;
  logic [PTR_W-1:0] dst;
  logic [MAT_W-1:0] wdata;
  logic wr, accept, legal;
  assign accept = state == IDLE && instr_valid && instr_ready;
  assign mem_write_data = wr & reset;
  assign mem_data_to_write = wdata;
  always_comb legal = instr_op != 2'b11 && instr_dst < LIM && (instr_op == 2'b10 || instr_src1 < LIM) && (instr_op != 2'b00 || instr_src2 < LIM);
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      op <= '0;
      dst <= '0;
      wdata <= '0;
      wr <= 1'b0;
      instr_ready <= 1'b0;
      mem_pointer1 <= '0;
      mem_pointer2 <= '0;
      mem_read_data <= 1'b0;
      mem_write_pointer <= '0;
      opa <= '0;
      opb <= '0;
      opnd_valid <= 1'b0;
      res_ready <= 1'b0;
      txn_done <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      txn_done <= 1'b0;
      err_illegal <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            op <= instr_op;
            dst <= instr_dst;
            instr_ready <= !legal;
            err_illegal <= !legal;
            if (legal && instr_op == 2'b10) begin
              wdata <= store_data;
              mem_write_pointer <= instr_dst;
              wr <= 1'b1;
              state <= WRITE;
            end else if (legal) begin
              mem_pointer1 <= instr_src1;
              mem_pointer2 <= instr_op == 2'b01 ? instr_src1 : instr_src2;
              mem_read_data <= 1'b1;
              state <= ISSUE;
            end
          end else instr_ready <= 1'b1;
        ISSUE: begin
          mem_read_data <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          opa <= mem_data1;
          opb <= mem_data2;
          if (op == 2'b01) begin
            wdata <= mem_data1;
            mem_write_pointer <= dst;
            wr <= 1'b1;
            state <= WRITE;
          end else begin
            opnd_valid <= 1'b1;
            state <= OPND;
          end
        end
        OPND:
          if (opnd_ready) begin
            opnd_valid <= 1'b0;
            res_ready <= 1'b1;
            state <= WAIT_RES;
          end
        WAIT_RES:
          if (res_valid) begin
            wdata <= res_data;
            res_ready <= 1'b0;
            mem_write_pointer <= dst;
            wr <= 1'b1;
            state <= WRITE;
          end
        WRITE: begin
          wr <= 1'b0;
          txn_done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          instr_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
